// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : RV32I load/store control. Runs a req/ready transaction with data
//            memory, aligns store lanes/byte enables, extends load data,
//            stalls upstream and flags misaligned, illegal and timed-out
//            accesses.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        MemRead,
  input  logic [3:0]  MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;
  localparam logic [7:0] CNT_LAST      = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        is_load_q;
  logic        dm_req_q;
  logic [31:0] dm_addr_q;
  logic [3:0]  dm_we_q;
  logic [31:0] dm_wdata_q;
  logic        done_q;
  logic [31:0] load_data_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  logic        access;
  logic        illegal;
  logic        misaligned;
  logic        is_half;
  logic        is_word;
  logic [3:0]  we_d;
  logic [31:0] wdata_d;
  logic [31:0] lane;
  logic [31:0] ext_d;

  // Decode the presented request: access detection, legality, alignment and lane steering
  always_comb begin
    access     = req_valid & (MemRead | (|MemWrite));
    illegal    = (MemRead && (|MemWrite)) ||
                 ((|MemWrite) && !(MemWrite == 4'b0001 || MemWrite == 4'b0011 ||
                                   MemWrite == 4'b1111)) ||
                 (MemRead && (Funct3 == 3'b011 || Funct3 == 3'b110 || Funct3 == 3'b111));
    // Width classes; Funct3 values aliasing onto these are already illegal
    is_half    = MemRead ? (Funct3[1:0] == 2'b01) : (MemWrite == 4'b0011);
    is_word    = MemRead ? (Funct3[1:0] == 2'b10) : (MemWrite == 4'b1111);
    misaligned = (is_half && addr[0]) || (is_word && (|addr[1:0]));
    we_d       = MemRead ? 4'b0000 : (MemWrite << addr[1:0]);
    case (MemWrite)
      4'b0001: wdata_d = {4{store_data[7:0]}};
      4'b0011: wdata_d = {2{store_data[15:0]}};
      default: wdata_d = store_data;
    endcase
  end

  // Extract and extend the addressed lane of the returned read word
  always_comb begin
    lane = dm_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext_d = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext_d = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext_d = {24'd0, lane[7:0]};
      3'b101:  ext_d = {16'd0, lane[15:0]};
      default: ext_d = lane;
    endcase
  end

  // Transaction FSM with registered memory-side and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      is_load_q   <= 1'b0;
      dm_req_q    <= 1'b0;
      dm_addr_q   <= 32'd0;
      dm_we_q     <= 4'd0;
      dm_wdata_q  <= 32'd0;
      done_q      <= 1'b0;
      load_data_q <= 32'd0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
            off_q     <= addr[1:0];
            f3_q      <= Funct3;
            is_load_q <= MemRead;
            dm_addr_q <= {addr[31:2], 2'b00};
            if (illegal) begin
              err_q      <= 1'b1;
              err_code_q <= CODE_ILLEGAL;
              state_q    <= S_ERR;
            end else if (misaligned) begin
              err_q      <= 1'b1;
              err_code_q <= CODE_MISALIGN;
              state_q    <= S_ERR;
            end else begin
              dm_req_q   <= 1'b1;
              dm_we_q    <= we_d;
              dm_wdata_q <= wdata_d;
              cnt_q      <= 8'd0;
              state_q    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // A ready on the last allowed cycle still completes the access
          if (dm_ready) begin
            if (is_load_q) begin
              load_data_q <= ext_d;
            end
            dm_req_q <= 1'b0;
            dm_we_q  <= 4'd0;
            done_q   <= 1'b1;
            state_q  <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            dm_req_q   <= 1'b0;
            dm_we_q    <= 4'd0;
            err_q      <= 1'b1;
            err_code_q <= CODE_TIMEOUT;
            state_q    <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RESP: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall holds the instruction from acceptance until the access ends
  always_comb begin
    stall = ((state_q == S_IDLE) && access) || (state_q == S_ACCESS);
  end

  assign dm_req    = dm_req_q;
  assign dm_addr   = dm_addr_q;
  assign dm_we     = dm_we_q;
  assign dm_wdata  = dm_wdata_q;
  assign done      = done_q;
  assign load_data = load_data_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit in the execute/memory stage of the RV32I core. It consumes the decoder's memory controls (`MemRead`, relative byte mask `MemWrite[3:0]`, `Funct3`) plus the ALU-computed address and rs2 data. It runs a handshaked transaction with the data memory, aligns store data and byte enables, and sign- or zero-extends load data. It stalls the pipeline until the access completes, and flags misaligned, illegal and timed-out accesses.

## Interface
- `TIMEOUT`, 16: maximum ACCESS cycles waiting for `dm_ready` before abort; range 2–255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: EX stage presents a memory instruction this cycle.
- `MemRead` in 1: load request, from the decoder.
- `MemWrite` in 4: relative store mask from the decoder; legal values 0000, 0001 (SB), 0011 (SH), 1111 (SW).
- `Funct3` in 3: load width/sign; legal values 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `addr` in 32: byte address from the ALU.
- `store_data` in 32: rs2 value.
- `dm_req` out 1: memory request, held high for the whole ACCESS state.
- `dm_addr` out 32: `{addr[31:2], 2'b00}`, registered at acceptance.
- `dm_we` out 4: absolute byte enables; 0000 for loads.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_ready` in 1: memory completes the request in this cycle.
- `dm_rdata` in 32: read word; valid when `dm_ready`=1.
- `stall` out 1: freeze upstream stages.
- `done` out 1: one-cycle completion pulse.
- `load_data` out 32: extended load result; valid while `done`=1 and held until the next load.
- `err` out 1: one-cycle pulse on misaligned, illegal or timeout.
- `err_code` out 2: 01 misaligned, 10 illegal, 11 timeout; held until the next error.

## Operation
- States: IDLE, ACCESS, RESP, ERR.
- A request is an access when `req_valid` & (`MemRead` | (`MemWrite` != 0)).
- In IDLE, an access is accepted. Address, data, mask and `Funct3` are latched.
- Illegal access:
  - both `MemRead` and `MemWrite` != 0, or
  - `MemWrite` not in {0001, 0011, 1111}, or
  - a load with `Funct3` in {011, 110, 111}.
- Misaligned access:
  - halfword with `addr[0]`=1, or
  - word with `addr[1:0]` != 00.
  - Illegal is checked before misaligned.
- Illegal or misaligned request: go to ERR; no `dm_req` is issued.
- Otherwise go to ACCESS and clear the timeout counter.
- Store byte enables: `dm_we` = mask << `addr[1:0]`.
- Store data by width:
  - SB: `{4{store_data[7:0]}}`
  - SH: `{2{store_data[15:0]}}`
  - SW: `store_data`
- ACCESS: `dm_req`=1 with `dm_addr`/`dm_we`/`dm_wdata` stable.
  - If `dm_ready`: a load captures `dm_rdata`; go to RESP.
  - Else the counter increments. When the counter reaches `TIMEOUT`-1 with no ready, go to ERR with code 11.
- Load extraction: let lane = `dm_rdata` >> (8·`addr[1:0]`).
  - LB/LH sign-extend bit 7/15 of lane.
  - LBU/LHU zero-extend.
  - LW uses the full word.
- RESP: `done`=1, update `load_data` (loads only), return to IDLE.
- ERR: `err`=1, update `err_code`, return to IDLE.
- `stall` = (IDLE & accepted access) | ACCESS. It is low in RESP, ERR, and IDLE when there is no access.
- `req_valid` outside IDLE is ignored; upstream holds the instruction via `stall`.
- Reset (any state, including mid-ACCESS): state IDLE and all outputs 0.
  - This covers `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `done`, `err`, `err_code`, `load_data`, `stall`, and the counter.
  - An in-flight transaction is abandoned; a late `dm_ready` is ignored.

## Timing
- Cycle 0: accept in IDLE.
- Cycle 1: `dm_req` rises. With zero-wait memory (`dm_ready` in cycle 1), `done` is high in cycle 2.
- Total latency: 2 + wait cycles.
- Error latency: `err` is high in cycle 1 (illegal/misaligned).
- Timeout: `err` is high `TIMEOUT`+1 cycles after acceptance.
- The next request can be accepted in the same cycle `done` or `err` is high? No: acceptance only in IDLE, so at the earliest the cycle after RESP/ERR. Back-to-back throughput is one access per 3 cycles.
- `dm_ready` is sampled only in ACCESS.

## Test plan
- LW, `addr`=0x100, `dm_rdata`=0xDEADBEEF, ready in the first ACCESS cycle:
  - `dm_addr`=0x100, `dm_we`=0000;
  - `done` in cycle 2 with `load_data`=0xDEADBEEF; `stall` high cycles 0–1 only.
- LB at 0x103 and LBU at 0x103 with `dm_rdata`=0x80112233 → `load_data` 0xFFFFFF80 and 0x00000080 respectively. LH at 0x102 with the same word → 0xFFFF8011.
- SB, `addr`=0x201, `store_data`=0x000000A5 → `dm_we`=0010, `dm_wdata`=0xA5A5A5A5, `dm_addr`=0x200. SH at 0x202 → `dm_we`=1100.
- Misaligned and illegal requests, each with no `dm_req` ever asserted:
  - SW at 0x302 → `err` in cycle 1, `err_code`=01.
  - Load with `Funct3`=011 → `err_code`=10.
  - `MemWrite`=0111 → `err_code`=10.
- `TIMEOUT`=4 with `dm_ready` held low → `dm_req` high exactly 4 cycles, then `err` with `err_code`=11 and `dm_req` low. A second run with ready on the 3rd wait cycle → `done`, no `err`.
- `rst`=0 during ACCESS, then `dm_ready`=1 the next cycle → all outputs 0 and no `done`. A fresh LW after reset release completes normally.
